sar_result_reader: RTL and testbench

Consumer side of the SAR conversion path: samples the `sar_out` word produced by the SAR logic at the end of each conversion frame and delivers it to downstream logic through a valid/ready stream. Frame boundaries come from the TMU `clk_out` strobe, sampled as a data input in the `clk` domain. The block buffers results in a small FIFO, discards start-up conversions, and flags overruns.

---
 rtl/sar_result_reader.sv | 92 +++++++++
 tb/tb_sar_result_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_result_reader.sv
// rtl/sar_result_reader.sv - SAR result capture FIFO with start-up skip and overrun flag
// Optional: SAR_READER_DROP_OLDEST_EN overwrites the oldest entry on overrun instead of dropping the new word.
module sar_result_reader #(
   parameter int PRECISION  = 10,
   parameter int DEPTH      = 4,
   parameter int SKIP_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     conv_clk,
   input  logic [PRECISION-1:0]     sar_in,
   output logic [PRECISION-1:0]     data_out,
   output logic                     valid,
   input  logic                     ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overrun,
   input  logic                     clr_ovr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic                 conv_q;
   logic                 conv_edge;
   logic                 capture;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 ovr_push;
   logic                 wr_en;
   logic                 rd_adv;
   logic [3:0]           skip_cnt;
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [PRECISION-1:0] mem [DEPTH];

   always_comb begin
      conv_edge = conv_clk & ~conv_q;
      capture   = conv_edge & en;
      push      = capture & (skip_cnt == 4'd0);
      valid     = (level != '0);
      pop       = valid & ready;
      full      = (level == LW'(DEPTH));
      ovr_push  = push & full & ~pop;
`ifdef SAR_READER_DROP_OLDEST_EN
      // Overrun push overwrites the head slot, so the read side advances with it.
      wr_en     = push;
      rd_adv    = pop | ovr_push;
`else
      wr_en     = push & ~ovr_push;
      rd_adv    = pop;
`endif
      data_out  = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         conv_q   <= 1'b1;
         skip_cnt <= 4'(SKIP_FIRST);
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overrun  <= 1'b0;
      end else begin
         conv_q <= conv_clk;
         if (!en)
            skip_cnt <= 4'(SKIP_FIRST);
         else if (capture && skip_cnt != 4'd0)
            skip_cnt <= skip_cnt - 4'd1;
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_adv)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !rd_adv)
            level <= level + LW'(1);
         else if (rd_adv && !wr_en)
            level <= level - LW'(1);
         // A new overrun takes priority over a same-cycle clear.
         if (ovr_push)
            overrun <= 1'b1;
         else if (clr_ovr)
            overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= sar_in;
   end

endmodule

// File: tb/tb_sar_result_reader.sv
// tb/tb_sar_result_reader.sv - randomized and directed check of sar_result_reader against a queue model
// Honours SAR_READER_DROP_OLDEST_EN when the same macro is defined for the bench.
module tb_sar_result_reader;

   localparam int PRECISION  = 10;
   localparam int DEPTH      = 4;
   localparam int SKIP_FIRST = 1;

   logic                 clk;
   logic                 rst;
   logic                 en;
   logic                 conv_clk;
   logic [PRECISION-1:0] sar_in;
   logic [PRECISION-1:0] data_out;
   logic                 valid;
   logic                 ready;
   logic [2:0]           level;
   logic                 overrun;
   logic                 clr_ovr;

   int total = 0;
   int bad   = 0;

   logic [PRECISION-1:0] mq[$];
   int                   m_skip;
   bit                   m_prev;
   bit                   m_ovr;
   bit                   cur_en;

   sar_result_reader #(
      .PRECISION (PRECISION),
      .DEPTH     (DEPTH),
      .SKIP_FIRST(SKIP_FIRST)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .conv_clk(conv_clk),
      .sar_in  (sar_in),
      .data_out(data_out),
      .valid   (valid),
      .ready   (ready),
      .level   (level),
      .overrun (overrun),
      .clr_ovr (clr_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit e, input bit c, input logic [PRECISION-1:0] s,
                             input bit rd, input bit cl);
      bit edge_seen;
      bit do_push;
      bit do_pop;
      bit ov;
      if (!r) begin
         mq.delete();
         m_prev = 1'b1;
         m_skip = SKIP_FIRST;
         m_ovr  = 1'b0;
         return;
      end
      edge_seen = c && !m_prev;
      m_prev    = c;
      do_pop    = (mq.size() != 0) && rd;
      do_push   = 1'b0;
      if (!e)
         m_skip = SKIP_FIRST;
      else if (edge_seen) begin
         if (m_skip > 0) m_skip--;
         else            do_push = 1'b1;
      end
      ov = do_push && (mq.size() == DEPTH) && !do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         if (ov) begin
`ifdef SAR_READER_DROP_OLDEST_EN
            void'(mq.pop_front());
            mq.push_back(s);
`endif
         end else begin
            mq.push_back(s);
         end
      end
      if (ov)      m_ovr = 1'b1;
      else if (cl) m_ovr = 1'b0;
   endtask

   task automatic cyc(input bit r, input bit e, input bit c, input logic [PRECISION-1:0] s,
                      input bit rd, input bit cl);
      rst = r; en = e; conv_clk = c; sar_in = s; ready = rd; clr_ovr = cl;
      model_step(r, e, c, s, rd, cl);
      @(negedge clk);
      check("valid", 32'(valid), 32'(mq.size() != 0));
      check("level", 32'(level), 32'(mq.size()));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (mq.size() != 0) check("data_out", 32'(data_out), 32'(mq[0]));
   endtask

   task automatic edge_word(input logic [PRECISION-1:0] w, input int gap, input bit rd, input bit cl);
      repeat (gap) cyc(1'b1, cur_en, 1'b0, PRECISION'($urandom), rd, 1'b0);
      cyc(1'b1, cur_en, 1'b1, w, rd, cl);
   endtask

   initial begin
      logic [PRECISION-1:0] exp_drain [4];
      logic [PRECISION-1:0] words [3];
      cur_en = 1'b1;

      // reset with conv_clk held high through release
      cyc(1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      cyc(1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0);
      edge_word(10'h111, 12, 1'b0, 1'b0);
      check("hold_skip_level", 32'(level), 32'd0);
      edge_word(10'h2A5, 12, 1'b0, 1'b0);
      check("first_valid", 32'(valid), 32'd1);
      check("first_word", 32'(data_out), 32'h2A5);

      // streaming with ready high
      words[0] = 10'h001; words[1] = 10'h3FF; words[2] = 10'h155;
      for (int i = 0; i < 3; i++) begin
         edge_word(words[i], 12, 1'b1, 1'b0);
         check("stream_word", 32'(data_out), 32'(words[i]));
         check("stream_level_le1", 32'(level <= 3'd1), 32'd1);
      end
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      check("stream_empty", 32'(level), 32'd0);

      // fill and overrun
      for (int i = 1; i <= 6; i++) begin
         edge_word(PRECISION'(i), 1, 1'b0, 1'b0);
         if (i == 5) begin
            check("fill_ovr", 32'(overrun), 32'd1);
            check("fill_level", 32'(level), 32'd4);
         end
      end
`ifdef SAR_READER_DROP_OLDEST_EN
      exp_drain[0] = 10'd3; exp_drain[1] = 10'd4; exp_drain[2] = 10'd5; exp_drain[3] = 10'd6;
`else
      exp_drain[0] = 10'd1; exp_drain[1] = 10'd2; exp_drain[2] = 10'd3; exp_drain[3] = 10'd4;
`endif
      for (int i = 0; i < 4; i++) begin
         check("drain_order", 32'(data_out), 32'(exp_drain[i]));
         cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      end
      check("drain_empty", 32'(valid), 32'd0);
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
      check("clr_alone", 32'(overrun), 32'd0);

      // full with simultaneous pop
      for (int i = 10; i <= 13; i++) edge_word(PRECISION'(i), 1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 10'd14, 1'b1, 1'b0);
      check("fullpop_ovr", 32'(overrun), 32'd0);
      check("fullpop_level", 32'(level), 32'd4);
      for (int i = 11; i <= 14; i++) begin
         check("fullpop_order", 32'(data_out), 32'(i));
         cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      end

      // enable toggle reloads the skip counter
      cur_en = 1'b0;
      repeat (3) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      cur_en = 1'b1;
      edge_word(10'h050, 3, 1'b0, 1'b0);
      check("en_skip", 32'(level), 32'd0);
      edge_word(10'h051, 3, 1'b0, 1'b0);
      check("en_push_level", 32'(level), 32'd1);
      check("en_push_word", 32'(data_out), 32'h051);
      for (int i = 2; i <= 4; i++) edge_word(PRECISION'(10'h050 + i), 1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 10'h055, 1'b0, 1'b1);
      check("set_beats_clr", 32'(overrun), 32'd1);
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
      check("clr_after", 32'(overrun), 32'd0);

      // reset mid-stream
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      check("mid_level3", 32'(level), 32'd3);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_valid", 32'(valid), 32'd0);
      edge_word(10'h060, 2, 1'b0, 1'b0);
      check("mid_rst_skip", 32'(level), 32'd0);
      edge_word(10'h061, 2, 1'b0, 1'b0);
      check("mid_rst_push", 32'(data_out), 32'h061);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 15) != 0),
             1'($urandom),
             PRECISION'($urandom),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
